// File: rtl/imm_decode_buf.sv
// Registered immediate generator: decodes each instruction word on push and queues
// the extended immediate, format, illegal flag and tag in a 2-entry valid/ready buffer.
module imm_decode_buf #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_buf: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Handshake: a word moves when valid and ready are both high at the rising edge.
    // in_ready comes from occupancy and rst only, never from out_ready.
    entry_t      slot0, slot1, new_entry;
    logic [1:0]  count;
    logic        push, pop;
    logic [6:0]  opc;
    logic        is_shift;
    logic [31:0] raw;
    logic        use_raw;
    logic [5:0]  shamt;

    assign opc      = in_instr[6:0];
    assign is_shift = (in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b101);

    always_comb begin
        new_entry         = '0;
        new_entry.tag     = in_tag;
        raw               = '0;
        use_raw           = 1'b0;
        shamt             = '0;
        case (opc)
            7'b0000011, 7'b1100111, 7'b1110011: begin
                new_entry.fmt = FMT_I;
                raw           = {{20{in_instr[31]}}, in_instr[31:20]};
                use_raw       = 1'b1;
            end
            7'b0010011, 7'b0011011: begin
                if (opc == 7'b0011011 && XLEN != 64) begin
                    new_entry.illegal = 1'b1;
                end else begin
                    new_entry.fmt = FMT_I;
                    if (is_shift) begin
                        // 6-bit shamt only for the full-width OP-IMM on RV64
                        shamt = (XLEN == 64 && opc == 7'b0010011) ? in_instr[25:20]
                                                                   : {1'b0, in_instr[24:20]};
                    end else begin
                        raw     = {{20{in_instr[31]}}, in_instr[31:20]};
                        use_raw = 1'b1;
                    end
                end
            end
            7'b0100011: begin
                new_entry.fmt = FMT_S;
                raw           = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                use_raw       = 1'b1;
            end
            7'b1100011: begin
                new_entry.fmt = FMT_B;
                raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
                use_raw = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                new_entry.fmt = FMT_U;
                raw           = {in_instr[31:12], 12'b0};
                use_raw       = 1'b1;
            end
            7'b1101111: begin
                new_entry.fmt = FMT_J;
                raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
                use_raw = 1'b1;
            end
            7'b0110011: new_entry.fmt = FMT_R;
            7'b0111011: begin
                if (XLEN != 64) new_entry.illegal = 1'b1;
                else            new_entry.fmt     = FMT_R;
            end
            default: new_entry.illegal = 1'b1;
        endcase
        if (use_raw) new_entry.imm = XLEN'($signed(raw));
        else         new_entry.imm = XLEN'(shamt);
    end

    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // slot0 is always the head; a pop from a full buffer shifts slot1 forward
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (pop && count == 2'd2) slot0 <= slot1;
            if (push) begin
                if (count == 2'd0 || (count == 2'd1 && pop)) slot0 <= new_entry;
                else                                         slot1 <= new_entry;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_imm     = slot0.imm;
    assign out_fmt     = slot0.fmt;
    assign out_illegal = slot0.illegal;
    assign out_tag     = slot0.tag;
endmodule

// File: tb/tb_imm_decode_buf.sv
// Bench for imm_decode_buf: XLEN=32 and XLEN=64 instances share stimulus and are
// checked against an arithmetic decode model and a queue model of the buffer.
module tb_imm_decode_buf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [7:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [7:0]  out_tag64;

    int checks = 0;
    int failures = 0;

    // entry layout: [75] illegal, [74:72] fmt, [71:64] tag, [63:0] imm
    logic [75:0] exp32_q[$];
    logic [75:0] exp64_q[$];

    always #5 clk = ~clk;

    imm_decode_buf #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    imm_decode_buf #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [75:0] ref_entry(input logic [31:0] w, input int xlen,
                                              input logic [7:0] tag);
        longint v   = 0;
        int     fmt = 0;
        bit     ill = 0;
        bit     sh  = (w[14:12] == 3'd1) || (w[14:12] == 3'd5);
        case (w[6:0])
            7'h03, 7'h67, 7'h73: begin
                fmt = 1; v = w[31:20]; if (v >= 2048) v -= 4096;
            end
            7'h13, 7'h1B: begin
                if (w[6:0] == 7'h1B && xlen != 64) ill = 1;
                else begin
                    fmt = 1;
                    if (sh) v = (xlen == 64 && w[6:0] == 7'h13) ? longint'(w[25:20])
                                                                : longint'(w[24:20]);
                    else begin v = w[31:20]; if (v >= 2048) v -= 4096; end
                end
            end
            7'h23: begin
                fmt = 2; v = {w[31:25], w[11:7]}; if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                fmt = 3; v = {w[31], w[7], w[30:25], w[11:8]}; v = v * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: begin
                fmt = 4; v = w[31:12]; v = v * 4096;
                if (w[31]) v -= 64'h1_0000_0000;
            end
            7'h6F: begin
                fmt = 5; v = {w[31], w[19:12], w[20], w[30:21]}; v = v * 2;
                if (v >= (64'd1 << 20)) v -= (64'd1 << 21);
            end
            7'h33: fmt = 0;
            7'h3B: if (xlen != 64) ill = 1;
            default: ill = 1;
        endcase
        return {ill, fmt[2:0], tag, 64'(v)};
    endfunction

    // one clock: drive at negedge, check state, then advance model at posedge
    task automatic cycle(input bit v, input logic [31:0] w, input logic [7:0] t,
                         input bit ordy, input bit r);
        logic [75:0] h;
        bit push, pop;
        rst = r; in_valid = v; in_instr = w; in_tag = t; out_ready = ordy;
        #1;
        check_eq("in_ready32", 64'(in_ready32), 64'(!r && exp32_q.size() < 2));
        check_eq("in_ready64", 64'(in_ready64), 64'(!r && exp64_q.size() < 2));
        check_eq("out_valid32", 64'(out_valid32), 64'(exp32_q.size() != 0));
        check_eq("out_valid64", 64'(out_valid64), 64'(exp64_q.size() != 0));
        if (exp32_q.size() != 0) begin
            h = exp32_q[0];
            check_eq("imm32", 64'(out_imm32), 64'(h[31:0]));
            check_eq("fmt32", 64'(out_fmt32), 64'(h[74:72]));
            check_eq("ill32", 64'(out_illegal32), 64'(h[75]));
            check_eq("tag32", 64'(out_tag32), 64'(h[71:64]));
        end
        if (exp64_q.size() != 0) begin
            h = exp64_q[0];
            check_eq("imm64", out_imm64, h[63:0]);
            check_eq("fmt64", 64'(out_fmt64), 64'(h[74:72]));
            check_eq("ill64", 64'(out_illegal64), 64'(h[75]));
            check_eq("tag64", 64'(out_tag64), 64'(h[71:64]));
        end
        push = v && !r && exp32_q.size() < 2;
        pop  = !r && ordy && exp32_q.size() != 0;
        @(posedge clk);
        if (r) begin
            exp32_q.delete();
            exp64_q.delete();
        end else begin
            if (pop) begin
                void'(exp32_q.pop_front());
                void'(exp64_q.pop_front());
            end
            if (push) begin
                exp32_q.push_back(ref_entry(w, 32, t));
                exp64_q.push_back(ref_entry(w, 64, t));
            end
        end
        @(negedge clk);
    endtask

    logic [6:0] opc_tab [15] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                                  7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h00, 7'h7F, 7'h0F};

    initial begin
        logic [31:0] w;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_valid32", 64'(out_valid32), 64'd0);
        check_eq("rst_imm32", 64'(out_imm32), 64'd0);
        check_eq("rst_fmt_ill_tag32", {53'd0, out_fmt32, out_illegal32, out_tag32}, 64'd0);
        check_eq("rst_imm64", out_imm64, 64'd0);
        check_eq("rst_ready64", 64'(in_ready64), 64'd1);
        @(negedge clk);

        cycle(1, 32'hFFF00093, 8'h11, 1, 0);
        check_eq("addi_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
        check_eq("addi_fmt32", 64'(out_fmt32), 64'd1);
        cycle(1, 32'h00112623, 8'h12, 1, 0);
        check_eq("sw_imm32", 64'(out_imm32), 64'h0000_000C);
        cycle(1, 32'hFE000EE3, 8'h13, 1, 0);
        check_eq("beq_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
        check_eq("beq_fmt32", 64'(out_fmt32), 64'd3);
        cycle(1, 32'h123450B7, 8'h14, 1, 0);
        check_eq("lui_imm64", out_imm64, 64'h0000_0000_1234_5000);
        check_eq("lui_fmt64", 64'(out_fmt64), 64'd4);
        cycle(1, 32'h4030D093, 8'h15, 1, 0);
        check_eq("srai_imm64", out_imm64, 64'd3);
        cycle(1, 32'h00000000, 8'h16, 1, 0);
        check_eq("ill0_flag32", 64'(out_illegal32), 64'd1);
        check_eq("ill0_tag32", 64'(out_tag32), 64'h16);
        cycle(1, 32'h0000001B, 8'h17, 1, 0);
        check_eq("op_imm_32_ill32", {60'd0, out_illegal32, out_fmt32}, 64'h8);
        check_eq("op_imm_32_fmt64", 64'(out_fmt64), 64'd1);
        cycle(1, 32'hFFF0009B, 8'h18, 1, 0);
        cycle(1, 32'h8000006F, 8'h19, 1, 0);
        repeat (2) cycle(0, 32'h0, 8'h0, 1, 0);

        // backpressure: tags 1,2 accepted, 3 held off while full
        cycle(1, 32'h00100093, 8'd1, 0, 0);
        cycle(1, 32'h00200093, 8'd2, 0, 0);
        cycle(1, 32'h00300093, 8'd3, 0, 0);
        cycle(1, 32'h00300093, 8'd3, 0, 0);
        cycle(1, 32'h00300093, 8'd3, 1, 0);
        cycle(1, 32'h00300093, 8'd3, 1, 0);
        repeat (3) cycle(0, 32'h0, 8'h0, 1, 0);

        // reset while full, alongside a push
        cycle(1, 32'h00400093, 8'd4, 0, 0);
        cycle(1, 32'h00500093, 8'd5, 0, 0);
        cycle(1, 32'h00600093, 8'd6, 0, 1);
        cycle(0, 32'h0, 8'h0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            w = $urandom();
            w[6:0] = opc_tab[$urandom_range(0, 14)];
            cycle($urandom_range(0, 3) != 0, w, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        end
        repeat (3) cycle(0, 32'h0, 8'h0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
